level_menu_ctrl: RTL and testbench

- Parametrised successor to the game-start screen controller.
- Runs the start menu: the keyboard moves a cursor over NUM_LEVELS levels, or selects a level directly with a digit key.
- Confirming a level checks the coin balance, issues a one-cycle charge pulse, and holds the selected level and ticket until the game ends.
- Also generates the scaled VGA frame-buffer address for the menu image; sits between the PS/2 key decoder, the coin counter and the game core.

---
 rtl/level_menu_ctrl_if.sv | 32 +++
 rtl/level_menu_ctrl.sv | 154 +++++++++++++++
 tb/tb_level_menu_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/level_menu_ctrl_if.sv
// Bus bundle between the start-menu controller and its neighbours.
// The controller takes the slave side. The keyboard decoder, coin counter,
// game core and VGA timing take the master side.
interface level_menu_ctrl_if #(
  parameter int unsigned LVL_W   = 3,
  parameter int unsigned MONEY_W = 7,
  parameter int unsigned ADDR_W  = 15
);
  logic               keydown;
  logic               ready;
  logic [8:0]         last_change;
  logic [MONEY_W-1:0] money;
  logic               game_over;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [ADDR_W-1:0]  pixel_addr;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   cursor;
  logic               ticket;
  logic               charge;
  logic               err;

  modport master (
    output keydown, ready, last_change, money, game_over, h_cnt, v_cnt,
    input  pixel_addr, level, cursor, ticket, charge, err
  );

  modport slave (
    input  keydown, ready, last_change, money, game_over, h_cnt, v_cnt,
    output pixel_addr, level, cursor, ticket, charge, err
  );
endinterface

// File: rtl/level_menu_ctrl.sv
// Start-menu controller. The keyboard moves a cursor over NUM_LEVELS levels
// or picks a level directly with a digit key. Enter checks the coin balance,
// issues a charge pulse and holds the level and ticket until the game ends.
// The controller also produces the downscaled menu-image pixel address.
// Optional: define LEVEL_MENU_HELP_EN to enable the '?' help screen.
module level_menu_ctrl #(
  parameter int unsigned NUM_LEVELS  = 3,
  parameter int unsigned LVL_W       = 3,
  parameter int unsigned MONEY_W     = 7,
  parameter int unsigned COST        = 10,
  parameter int unsigned ERR_CYCLES  = 16,
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15
) (
  input logic              clk,
  input logic              rst,
  level_menu_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
`ifdef LEVEL_MENU_HELP_EN
  localparam logic [8:0] KEY_HELP  = 9'h04A;

  typedef enum logic [1:0] {S_MENU, S_PLAY, S_ERR, S_HELP} state_t;
`else
  typedef enum logic [1:0] {S_MENU, S_PLAY, S_ERR} state_t;
`endif

  state_t           state;
  logic             held;
  logic [CNT_W-1:0] err_cnt;

  logic             key_evt;
  logic [3:0]       digit;
  logic             digit_sel;
  logic [LVL_W-1:0] start_lvl;
  logic             do_enter;
  logic             funds_ok;
  logic             go_menu;

  // Key edge detection, digit decoding and the derived menu actions
  always_comb begin
    key_evt = bus.keydown & bus.ready & ~held;
    digit   = 4'd0;
    case (bus.last_change)
      9'h016:  digit = 4'd1;
      9'h01E:  digit = 4'd2;
      9'h026:  digit = 4'd3;
      9'h025:  digit = 4'd4;
      9'h02E:  digit = 4'd5;
      9'h036:  digit = 4'd6;
      9'h03D:  digit = 4'd7;
      9'h03E:  digit = 4'd8;
      9'h046:  digit = 4'd9;
      default: digit = 4'd0;
    endcase
    digit_sel = key_evt && (digit != 4'd0) && (32'(digit) <= NUM_LEVELS);
    start_lvl = digit_sel ? LVL_W'(digit - 4'd1) : bus.cursor;
    do_enter  = digit_sel || (key_evt && (bus.last_change == KEY_ENTER));
    funds_ok  = (bus.money >= MONEY_W'(COST));
    go_menu   = bus.game_over || (key_evt && (bus.last_change == KEY_ESC));
  end

  // Press tracker. Starts set so a key held through reset must be released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 1'b1;
    end else if (!bus.keydown) begin
      held <= 1'b0;
    end else if (bus.ready) begin
      held <= 1'b1;
    end
  end

  // Menu / play / error state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_MENU;
      bus.level  <= '0;
      bus.cursor <= '0;
      bus.ticket <= 1'b0;
      bus.charge <= 1'b0;
      bus.err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      bus.charge <= 1'b0;
      case (state)
        S_MENU: begin
          if (do_enter) begin
            bus.cursor <= start_lvl;
            if (funds_ok) begin
              bus.level  <= start_lvl + LVL_W'(1);
              bus.ticket <= 1'b1;
              bus.charge <= 1'b1;
              state      <= S_PLAY;
            end else begin
              bus.err <= 1'b1;
              err_cnt <= CNT_W'(ERR_CYCLES - 1);
              state   <= S_ERR;
            end
          end else if (key_evt && (bus.last_change == KEY_UP)) begin
            bus.cursor <= (bus.cursor == '0) ? LVL_W'(NUM_LEVELS - 1)
                                             : bus.cursor - LVL_W'(1);
          end else if (key_evt && (bus.last_change == KEY_DOWN)) begin
            bus.cursor <= (bus.cursor == LVL_W'(NUM_LEVELS - 1)) ? '0
                                             : bus.cursor + LVL_W'(1);
          end
`ifdef LEVEL_MENU_HELP_EN
          else if (key_evt && (bus.last_change == KEY_HELP)) begin
            bus.level  <= LVL_W'(NUM_LEVELS + 1);
            bus.ticket <= 1'b0;
            state      <= S_HELP;
          end
`endif
        end
        S_PLAY: begin
          if (go_menu) begin
            bus.level  <= '0;
            bus.ticket <= 1'b0;
            state      <= S_MENU;
          end
        end
        S_ERR: begin
          if (err_cnt == '0) begin
            bus.err <= 1'b0;
            state   <= S_MENU;
          end else begin
            err_cnt <= err_cnt - CNT_W'(1);
          end
        end
`ifdef LEVEL_MENU_HELP_EN
        S_HELP: begin
          if (go_menu) begin
            bus.level <= '0;
            state     <= S_MENU;
          end
        end
`endif
        default: state <= S_MENU;
      endcase
    end
  end

  // Downscaled menu image address, independent of state
  assign bus.pixel_addr = ADDR_W'(32'(bus.h_cnt >> SCALE_SHIFT)
                                  + 32'(IMG_W) * 32'(bus.v_cnt >> SCALE_SHIFT));

endmodule

// File: tb/tb_level_menu_ctrl.sv
// Bench for level_menu_ctrl: an event-level reference model is compared every
// cycle, and directed scenarios are pinned with hand-computed values.
module tb_level_menu_ctrl;

  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_HELP  = 9'h04A;
  localparam logic [8:0] K_1     = 9'h016;
  localparam logic [8:0] K_2     = 9'h01E;
  localparam logic [8:0] K_5     = 9'h02E;

  localparam int M_MENU = 0;
  localparam int M_PLAY = 1;
  localparam int M_ERR  = 2;
  localparam int M_HELP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  level_menu_ctrl_if #(.LVL_W(3), .MONEY_W(7), .ADDR_W(15)) bus ();

  level_menu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_charge = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: game mode as an int, the error window as a cycle deadline
  logic [8:0] digit_codes [9] = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
                                  9'h036, 9'h03D, 9'h03E, 9'h046};

  function automatic int digit_of(input logic [8:0] c);
    for (int i = 0; i < 9; i++) if (c == digit_codes[i]) return i + 1;
    return 0;
  endfunction

  int mode = M_MENU;
  int m_cursor = 0, m_level = 0, m_ticket = 0, m_charge = 0;
  int err_end = 0, cyc = 0;
  bit armed = 0;

  always @(posedge clk) begin
    bit evt;
    bit start;
    int k;
    logic [8:0] code;
    cyc++;
    if (rst) begin
      mode = M_MENU; m_cursor = 0; m_level = 0; m_ticket = 0; m_charge = 0;
      armed = 0;
    end else begin
      evt = bus.keydown && bus.ready && armed;
      if (!bus.keydown) armed = 1;
      else if (bus.ready) armed = 0;
      m_charge = 0;
      code = bus.last_change;
      k = digit_of(code);
      start = 0;
      case (mode)
        M_MENU: if (evt) begin
          if (k >= 1 && k <= 3) begin m_cursor = k - 1; start = 1; end
          else if (code == K_ENTER) start = 1;
          else if (code == K_UP)   m_cursor = (m_cursor + 2) % 3;
          else if (code == K_DOWN) m_cursor = (m_cursor + 1) % 3;
`ifdef LEVEL_MENU_HELP_EN
          else if (code == K_HELP) begin mode = M_HELP; m_level = 4; m_ticket = 0; end
`endif
          if (start) begin
            if (int'(bus.money) >= 10) begin
              mode = M_PLAY; m_level = m_cursor + 1; m_ticket = 1; m_charge = 1;
            end else begin
              mode = M_ERR; err_end = cyc + 16;
            end
          end
        end
        M_PLAY: if (bus.game_over || (evt && code == K_ESC)) begin
          mode = M_MENU; m_level = 0; m_ticket = 0;
        end
        M_ERR: if (cyc == err_end) mode = M_MENU;
        M_HELP: if (bus.game_over || (evt && code == K_ESC)) begin
          mode = M_MENU; m_level = 0;
        end
        default: mode = M_MENU;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int exp_addr;
    exp_addr = (int'(bus.h_cnt) / 4 + 160 * (int'(bus.v_cnt) / 4)) % 32768;
    chk("pixel_addr", int'(bus.pixel_addr), exp_addr);
    if (rst) begin
      chk("rst_level",  int'(bus.level),  0);
      chk("rst_cursor", int'(bus.cursor), 0);
      chk("rst_ticket", int'(bus.ticket), 0);
      chk("rst_charge", int'(bus.charge), 0);
      chk("rst_err",    int'(bus.err),    0);
    end else begin
      chk("level",  int'(bus.level),  m_level);
      chk("cursor", int'(bus.cursor), m_cursor);
      chk("ticket", int'(bus.ticket), m_ticket);
      chk("charge", int'(bus.charge), m_charge);
      chk("err",    int'(bus.err),    (mode == M_ERR) ? 1 : 0);
      if (bus.charge) n_charge++;
      if (bus.err) n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [8:0] c, input int hold);
    bus.last_change = c; bus.keydown = 1'b1; bus.ready = 1'b1;
    tick(hold);
    bus.keydown = 1'b0; bus.ready = 1'b0;
    tick(2);
  endtask

  task automatic pulse_game_over();
    bus.game_over = 1'b1;
    tick(1);
    bus.game_over = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.keydown = 0; bus.ready = 0; bus.last_change = '0; bus.money = '0;
    bus.game_over = 0; bus.h_cnt = '0; bus.v_cnt = '0;
    tick(3);
    chk("reset_level",  int'(bus.level),  0);
    chk("reset_cursor", int'(bus.cursor), 0);
    rst = 1'b0;
    tick(2);

    // Down then Enter with exactly enough coins
    bus.money = 7'd10; n_charge = 0;
    press(K_DOWN, 1);
    press(K_ENTER, 1);
    chk("t1_cursor",  int'(bus.cursor), 1);
    chk("t1_level",   int'(bus.level),  2);
    chk("t1_ticket",  int'(bus.ticket), 1);
    chk("t1_charges", n_charge, 1);
    pulse_game_over();
    chk("t1_level_end", int'(bus.level), 0);

    // Short of one coin: direct digit '2' enters the error window
    bus.money = 7'd9; n_err = 0; n_charge = 0;
    press(K_2, 1);
    tick(20);
    chk("t2_err_cycles", n_err, 16);
    chk("t2_charges",    n_charge, 0);
    chk("t2_level",      int'(bus.level), 0);
    chk("t2_cursor",     int'(bus.cursor), 1);
    chk("t2_err_clear",  int'(bus.err), 0);

    // Cursor wrapping and an out-of-range digit
    press(K_1, 1);
    tick(20);
    chk("t3_cursor0", int'(bus.cursor), 0);
    press(K_UP, 1);
    chk("t3_up_wrap", int'(bus.cursor), 2);
    press(K_DOWN, 1);
    chk("t3_down_wrap", int'(bus.cursor), 0);
    press(K_5, 1);
    chk("t3_digit5_cursor", int'(bus.cursor), 0);
    chk("t3_digit5_err",    int'(bus.err), 0);

    // Long hold gives one event; game_over together with Esc
    bus.money = 7'd10; n_charge = 0;
    press(K_ENTER, 100);
    chk("t4_level",   int'(bus.level), 1);
    chk("t4_charges", n_charge, 1);
    bus.money = 7'd0;
    press(K_ENTER, 1);
    chk("t4_no_recharge", n_charge, 1);
    bus.last_change = K_ESC; bus.keydown = 1; bus.ready = 1; bus.game_over = 1;
    tick(1);
    bus.game_over = 0; bus.keydown = 0; bus.ready = 0;
    tick(2);
    chk("t4_end_level",  int'(bus.level), 0);
    chk("t4_end_ticket", int'(bus.ticket), 0);
    bus.money = 7'd10;
    press(K_ENTER, 1);
    chk("t4_restart_level", int'(bus.level), 1);
    chk("t4_restart_chg",   n_charge, 2);
    pulse_game_over();

    // Reset mid-ERROR and mid-PLAY
    bus.money = 7'd9;
    press(K_DOWN, 1);
    press(K_ENTER, 1);
    tick(3);
    chk("t5_in_err", int'(bus.err), 1);
    rst = 1'b1; #1;
    chk("t5_err_rst_err",    int'(bus.err), 0);
    chk("t5_err_rst_cursor", int'(bus.cursor), 0);
    tick(2); rst = 1'b0; tick(2);
    bus.money = 7'd10;
    press(K_DOWN, 1);
    press(K_ENTER, 1);
    chk("t5_in_play", int'(bus.level), 2);
    rst = 1'b1; #1;
    chk("t5_play_rst_level",  int'(bus.level), 0);
    chk("t5_play_rst_ticket", int'(bus.ticket), 0);
    chk("t5_play_rst_cursor", int'(bus.cursor), 0);
    tick(2); rst = 1'b0; tick(2);

    // A key held through reset does not fire until pressed again
    n_charge = 0;
    bus.last_change = K_ENTER; bus.keydown = 1; bus.ready = 1;
    rst = 1'b1; tick(2); rst = 1'b0; tick(5);
    chk("t5_held_level",   int'(bus.level), 0);
    chk("t5_held_charges", n_charge, 0);
    bus.keydown = 0; bus.ready = 0; tick(2);
    press(K_ENTER, 1);
    chk("t5_repress_level", int'(bus.level), 1);
    pulse_game_over();

    // Pixel address corners
    bus.h_cnt = 10'd639; bus.v_cnt = 10'd479; tick(1);
    chk("pix_corner", int'(bus.pixel_addr), 19199);
    bus.h_cnt = 10'd7; bus.v_cnt = 10'd5; tick(1);
    chk("pix_small", int'(bus.pixel_addr), 161);
    bus.h_cnt = 10'd0; bus.v_cnt = 10'd0; tick(1);
    chk("pix_zero", int'(bus.pixel_addr), 0);

    // Help key
    bus.money = 7'd0;
    press(K_HELP, 1);
`ifdef LEVEL_MENU_HELP_EN
    chk("help_level",  int'(bus.level), 4);
    chk("help_ticket", int'(bus.ticket), 0);
    chk("help_err",    int'(bus.err), 0);
    press(K_ESC, 1);
    chk("help_exit_level", int'(bus.level), 0);
`else
    chk("help_ignored_level", int'(bus.level), 0);
    chk("help_ignored_err",   int'(bus.err), 0);
`endif
    tick(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
